// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the vector-MAC job sequencer.
// Register offsets are APB word indices (byte offset >> 2).
package acc_seq_pkg;

   localparam int DEF_NUM_ELEM = 1024;
   localparam int DEF_CHUNK    = 16;

   localparam int REG_CTRL    = 0;
   localparam int REG_LEN     = 1;
   localparam int REG_STATUS  = 2;
   localparam int REG_TIMEOUT = 3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_ABORT  = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TOUT    = 2;
   localparam int STAT_SPUR    = 3;
   localparam int STAT_CNT_LSB = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } seq_state_t;

endpackage

// File: rtl/acc_seq_regif.sv
// APB register file for the sequencer: decode, sticky status bits,
// start/abort pulses, registered level interrupt and read mux.
module acc_seq_regif
   import acc_seq_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_ELEM       = DEF_NUM_ELEM,
   parameter int CHUNK_IDX_W    = 6,
   parameter int TO_W           = 16,
   parameter int LEN_W          = $clog2(NUM_ELEM + 1)
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PSLVERR,
   input  logic                      busy,
   input  logic                      done_set,
   input  logic                      tout_set,
   input  logic                      spur_set,
   input  logic [CHUNK_IDX_W-1:0]    cmpl_cnt,
   output logic                      start,
   output logic                      abort,
   output logic [LEN_W-1:0]          len,
   output logic [TO_W-1:0]           to_val,
   output logic                      irq_o
);

   localparam int WIDX_W = APB_ADDR_WIDTH - 2;

   logic [WIDX_W-1:0] widx;
   logic              wr_en, sel_ctrl, sel_len, sel_stat, sel_to;
   logic [31:0]       w1c;
   logic              irq_en_q, done_q, tout_q, spur_q, irq_q;
   logic              unused_addr;

   assign widx        = PADDR[APB_ADDR_WIDTH-1:2];
   assign unused_addr = ^PADDR[1:0];
   assign wr_en       = PSEL & PENABLE & PWRITE;
   assign sel_ctrl    = (widx == WIDX_W'(REG_CTRL));
   assign sel_len     = (widx == WIDX_W'(REG_LEN));
   assign sel_stat    = (widx == WIDX_W'(REG_STATUS));
   assign sel_to      = (widx == WIDX_W'(REG_TIMEOUT));
   assign w1c         = (wr_en & sel_stat) ? PWDATA : 32'h0;

   assign start   = wr_en & sel_ctrl & PWDATA[CTRL_START];
   assign abort   = wr_en & sel_ctrl & PWDATA[CTRL_ABORT];
   assign PSLVERR = wr_en & busy & (sel_len | sel_to);
   assign irq_o   = irq_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         irq_en_q <= 1'b0;
         len      <= '0;
         to_val   <= '0;
         done_q   <= 1'b0;
         tout_q   <= 1'b0;
         spur_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_en & sel_ctrl) irq_en_q <= PWDATA[CTRL_IRQ_EN];
         if (wr_en & sel_len & ~busy)
            len <= (PWDATA > 32'(NUM_ELEM)) ? LEN_W'(NUM_ELEM) : PWDATA[LEN_W-1:0];
         if (wr_en & sel_to & ~busy) to_val <= PWDATA[TO_W-1:0];
         // hardware set takes priority over a same-cycle W1C
         done_q <= done_set | (done_q & ~w1c[STAT_DONE]);
         tout_q <= tout_set | (tout_q & ~w1c[STAT_TOUT]);
         spur_q <= spur_set | (spur_q & ~w1c[STAT_SPUR]);
         irq_q  <= irq_en_q & (done_q | tout_q);
      end
   end

   always_comb begin
      PRDATA = 32'hFFFF_FFFF;
      if (sel_ctrl) begin
         PRDATA              = 32'h0;
         PRDATA[CTRL_IRQ_EN] = irq_en_q;
      end else if (sel_len) begin
         PRDATA = 32'(len);
      end else if (sel_stat) begin
         PRDATA                                = 32'h0;
         PRDATA[STAT_BUSY]                     = busy;
         PRDATA[STAT_DONE]                     = done_q;
         PRDATA[STAT_TOUT]                     = tout_q;
         PRDATA[STAT_SPUR]                     = spur_q;
         PRDATA[STAT_CNT_LSB +: CHUNK_IDX_W]   = cmpl_cnt;
      end else if (sel_to) begin
         PRDATA = 32'(to_val);
      end
   end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Chunked job sequencer for the vector MAC core: issues one command per
// CHUNK elements over valid/ready and waits for each response pulse.
module acc_seq_ctrl
   import acc_seq_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_ELEM       = DEF_NUM_ELEM,
   parameter int CHUNK          = DEF_CHUNK,
   parameter int CHUNK_IDX_W    = 6,
   parameter int TO_W           = 16
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [CHUNK_IDX_W-1:0]    cmd_chunk,
   output logic                      cmd_last,
   input  logic                      rsp_valid,
   output logic                      irq_o
);

   localparam int LEN_W = $clog2(NUM_ELEM + 1);
   localparam int CSH   = $clog2(CHUNK);

   seq_state_t             state, state_n;
   logic [CHUNK_IDX_W-1:0] chunk_q, chunk_n, cmpl_q, cmpl_n, last_idx;
   logic [TO_W-1:0]        to_cnt, to_cnt_n, to_val;
   logic [TO_W:0]          to_inc;
   logic [LEN_W-1:0]       len;
   logic [LEN_W:0]         len_rnd, nchunk;
   logic                   start, abort, busy, expire;
   logic                   done_set, tout_set, spur_set;

   assign PREADY = 1'b1;

   acc_seq_regif #(
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
      .NUM_ELEM       (NUM_ELEM),
      .CHUNK_IDX_W    (CHUNK_IDX_W),
      .TO_W           (TO_W),
      .LEN_W          (LEN_W)
   ) u_regif (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA   (PRDATA),
      .PSLVERR  (PSLVERR),
      .busy     (busy),
      .done_set (done_set),
      .tout_set (tout_set),
      .spur_set (spur_set),
      .cmpl_cnt (cmpl_q),
      .start    (start),
      .abort    (abort),
      .len      (len),
      .to_val   (to_val),
      .irq_o    (irq_o)
   );

   // CHUNK is a power of two, so ceil(LEN/CHUNK) is a round-up then shift
   assign len_rnd  = {1'b0, len} + (LEN_W+1)'(CHUNK - 1);
   assign nchunk   = len_rnd >> CSH;
   assign last_idx = CHUNK_IDX_W'(nchunk - (LEN_W+1)'(1));

   assign busy      = (state != S_IDLE);
   assign cmd_chunk = chunk_q;
   assign cmd_last  = busy & (chunk_q == last_idx);
   // abort withdraws valid in its own cycle so no handshake can slip through
   assign cmd_valid = (state == S_ISSUE) & ~abort;
   assign spur_set  = rsp_valid & (state != S_WAIT);
   assign to_inc    = {1'b0, to_cnt} + (TO_W+1)'(1);
   assign expire    = (to_val != '0) & (to_inc == {1'b0, to_val});

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= S_IDLE;
         chunk_q <= '0;
         cmpl_q  <= '0;
         to_cnt  <= '0;
      end else begin
         state   <= state_n;
         chunk_q <= chunk_n;
         cmpl_q  <= cmpl_n;
         to_cnt  <= to_cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      chunk_n  = chunk_q;
      cmpl_n   = cmpl_q;
      to_cnt_n = to_cnt;
      done_set = 1'b0;
      tout_set = 1'b0;
      if (abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  chunk_n = '0;
                  cmpl_n  = '0;
                  if (len == '0) done_set = 1'b1;
                  else           state_n  = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  state_n  = S_WAIT;
                  to_cnt_n = '0;
               end
            end
            S_WAIT: begin
               to_cnt_n = to_inc[TO_W-1:0];
               if (rsp_valid) begin
                  cmpl_n = cmpl_q + 1'b1;
                  if (chunk_q == last_idx) begin
                     state_n  = S_IDLE;
                     done_set = 1'b1;
                  end else begin
                     state_n = S_ISSUE;
                     chunk_n = chunk_q + 1'b1;
                  end
               end else if (expire) begin
                  state_n  = S_IDLE;
                  tout_set = 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: directed scenarios plus randomized
// jobs checked against a chunk-list / status model built from LEN.
module tb_acc_seq_ctrl;

   localparam logic [11:0] A_CTRL = 12'h000, A_LEN = 12'h004,
                           A_STAT = 12'h008, A_TO  = 12'h00C, A_BAD = 12'h010;

   logic        HCLK = 1'b0, HRESETn = 1'b0;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY, PSLVERR;
   logic        cmd_valid, cmd_ready, cmd_last, rsp_valid, irq_o;
   logic [5:0]  cmd_chunk;

   int n_cmp = 0, n_err = 0, cyc = 0;
   int ready_mode = 0;   // 0 low, 1 high, 2 random
   int rsp_en = 0, rsp_dly = 3, rsp_cnt = 0, spur_req = 0, last_acc_cyc = 0;
   logic [5:0] obs_chunk[$];
   logic       obs_last[$];

   acc_seq_ctrl dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_chunk(cmd_chunk), .cmd_last(cmd_last),
      .rsp_valid(rsp_valid), .irq_o(irq_o)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // core model: drives ready, records handshakes, answers after rsp_dly cycles
   initial begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      forever begin
         @(negedge HCLK);
         case (ready_mode)
            0:       cmd_ready = 1'b0;
            1:       cmd_ready = 1'b1;
            default: cmd_ready = 1'($urandom_range(0, 1));
         endcase
         rsp_valid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && rsp_en != 0) rsp_valid = 1'b1;
         end
         if (spur_req != 0) begin
            rsp_valid = 1'b1;
            spur_req  = 0;
         end
         if (HRESETn && cmd_valid && cmd_ready) begin
            obs_chunk.push_back(cmd_chunk);
            obs_last.push_back(cmd_last);
            last_acc_cyc = cyc + 1;
            rsp_cnt = (rsp_dly != 0) ? rsp_dly : int'($urandom_range(1, 6));
         end
      end
   end

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      #1 err = PSLVERR;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      #1 d = PRDATA;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output logic [31:0] st);
      for (int i = 0; i < 3000; i++) begin
         apb_read(A_STAT, st);
         if (!st[0]) break;
      end
      chk(tag, {31'b0, st[0]}, 32'h0);
   endtask

   task automatic wait_obs(input string tag, input int n);
      for (int i = 0; i < 500; i++) begin
         if (obs_chunk.size() >= n) break;
         @(negedge HCLK);
      end
      chk(tag, 32'(obs_chunk.size() >= n), 32'h1);
   endtask

   // expected chunk sequence is 0..ceil(len/16)-1 with last only on the final one
   task automatic chk_job(input string tag, input int len);
      int n = (len + 15) / 16;
      chk({tag, "_ncmd"}, 32'(obs_chunk.size()), 32'(n));
      for (int i = 0; i < n && i < obs_chunk.size(); i++) begin
         chk({tag, "_chunk"}, 32'(obs_chunk[i]), 32'(i));
         chk({tag, "_last"}, 32'(obs_last[i]), 32'(i == n - 1));
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          len, tov, ien, n;

      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_valid", 32'(cmd_valid), 0);
      chk("rst_irq", 32'(irq_o), 0);
      HRESETn = 1'b1;
      apb_read(A_CTRL, d); chk("rst_ctrl", d, 0);
      apb_read(A_LEN, d);  chk("rst_len", d, 0);
      apb_read(A_STAT, d); chk("rst_stat", d, 0);
      apb_read(A_TO, d);   chk("rst_to", d, 0);
      apb_read(A_BAD, d);  chk("bad_rd", d, 32'hFFFF_FFFF);
      chk("rst_chunk", 32'(cmd_chunk), 0);
      chk("rst_last", 32'(cmd_last), 0);
      chk("pready", 32'(PREADY), 1);

      // LEN=40: three chunks, response 3 cycles after accept
      ready_mode = 1; rsp_en = 1; rsp_dly = 3;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_LEN, 40, e); chk("len_err", 32'(e), 0);
      apb_write(A_CTRL, 32'h3, e);
      wait_idle("j40_idle", d);
      chk("j40_stat", d, 32'h0003_0002);
      chk_job("j40", 40);
      chk("j40_irq", 32'(irq_o), 1);
      apb_write(A_STAT, 32'hE, e);

      // ready held low: valid and chunk must hold
      ready_mode = 0;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_LEN, 32, e);
      apb_write(A_TO, 8, e);
      apb_write(A_CTRL, 32'h1, e);
      for (int i = 0; i < 10; i++) begin
         @(negedge HCLK);
         chk("stall_valid", 32'(cmd_valid), 1);
         chk("stall_chunk", 32'(cmd_chunk), 0);
      end
      ready_mode = 1;
      wait_idle("stall_idle", d);
      chk("stall_stat", d, 32'h0002_0002);
      chk_job("stall", 32);

      // timeout with no response
      apb_write(A_STAT, 32'hE, e);
      rsp_en = 0;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_TO, 5, e);
      apb_write(A_LEN, 16, e);
      apb_write(A_CTRL, 32'h3, e);
      wait_obs("to_acc", 1);
      for (int i = 0; i < 50; i++) begin
         if (irq_o) break;
         @(negedge HCLK);
      end
      chk("to_irq_cyc", 32'(cyc), 32'(last_acc_cyc + 6));
      apb_read(A_STAT, d); chk("to_stat", d, 32'h0000_0004);
      apb_write(A_STAT, 32'h4, e);
      chk("to_irq_hold", 32'(irq_o), 1);
      @(posedge HCLK); #1;
      chk("to_irq_drop", 32'(irq_o), 0);
      apb_write(A_TO, 0, e);

      // abort while waiting on chunk 1, then restart from chunk 0
      rsp_en = 1; rsp_dly = 5;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_LEN, 64, e);
      apb_write(A_CTRL, 32'h1, e);
      wait_obs("ab_obs", 2);
      rsp_en = 0;
      apb_write(A_CTRL, 32'h4, e);
      chk("ab_valid", 32'(cmd_valid), 0);
      apb_read(A_STAT, d); chk("ab_stat", d, 32'h0001_0000);
      repeat (8) @(posedge HCLK);
      rsp_en = 1; rsp_dly = 2;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_CTRL, 32'h1, e);
      wait_idle("ab2_idle", d);
      chk("ab2_stat", d, 32'h0004_0002);
      chk_job("ab2", 64);
      apb_write(A_STAT, 32'hE, e);

      // LEN saturation, writes while busy, zero-length job
      apb_write(A_LEN, 2000, e);
      apb_read(A_LEN, d); chk("len_sat", d, 1024);
      apb_write(A_LEN, 16, e);
      ready_mode = 0;
      apb_write(A_CTRL, 32'h1, e);
      apb_write(A_LEN, 5, e);  chk("busy_len_err", 32'(e), 1);
      apb_read(A_LEN, d);      chk("busy_len_keep", d, 16);
      apb_write(A_TO, 9, e);   chk("busy_to_err", 32'(e), 1);
      apb_read(A_TO, d);       chk("busy_to_keep", d, 0);
      apb_write(A_CTRL, 32'h5, e); // abort beats start
      apb_read(A_STAT, d);     chk("abst_stat", d & 32'hF, 0);
      apb_write(A_LEN, 0, e);  chk("idle_len_err", 32'(e), 0);
      ready_mode = 1;
      obs_chunk.delete(); obs_last.delete();
      apb_write(A_CTRL, 32'h1, e);
      repeat (5) @(negedge HCLK);
      chk("len0_ncmd", 32'(obs_chunk.size()), 0);
      apb_read(A_STAT, d); chk("len0_stat", d & 32'hF, 32'h2);
      apb_write(A_STAT, 32'hE, e);

      // response pulse while idle
      spur_req = 1;
      repeat (3) @(posedge HCLK);
      apb_read(A_STAT, d); chk("spur_stat", d & 32'hF, 32'h8);
      apb_write(A_BAD, 32'h1, e); chk("bad_wr_err", 32'(e), 0);
      apb_write(A_STAT, 32'h8, e);
      apb_read(A_STAT, d); chk("spur_clr", d & 32'hF, 0);

      // randomized jobs
      for (int it = 0; it < 8; it++) begin
         len = (it == 0) ? 1024 : int'($urandom_range(1, 300));
         tov = ($urandom_range(0, 1) != 0) ? int'($urandom_range(7, 20)) : 0;
         ien = int'($urandom_range(0, 1));
         n   = (len + 15) / 16;
         ready_mode = 2; rsp_en = 1; rsp_dly = 0;
         obs_chunk.delete(); obs_last.delete();
         apb_write(A_LEN, 32'(len), e);
         apb_write(A_TO, 32'(tov), e);
         apb_read(A_LEN, d); chk("rnd_len", d, 32'(len));
         apb_write(A_CTRL, 32'(1 + 2 * ien), e);
         wait_idle("rnd_idle", d);
         chk("rnd_stat", d, 32'h2 | (32'(n % 64) << 16));
         chk_job("rnd", len);
         chk("rnd_irq", 32'(irq_o), 32'(ien));
         apb_write(A_STAT, 32'hF, e);
         apb_read(A_STAT, d); chk("rnd_clr", d & 32'hF, 0);
      end

      // asynchronous reset in the middle of ISSUE
      ready_mode = 0;
      apb_write(A_LEN, 48, e);
      apb_write(A_TO, 7, e);
      apb_write(A_CTRL, 32'h3, e);
      @(negedge HCLK);
      chk("mid_valid", 32'(cmd_valid), 1);
      #2 HRESETn = 1'b0;
      #1 chk("arst_valid", 32'(cmd_valid), 0);
      chk("arst_last", 32'(cmd_last), 0);
      @(posedge HCLK); #1 HRESETn = 1'b1;
      apb_read(A_CTRL, d); chk("arst_ctrl", d, 0);
      apb_read(A_LEN, d);  chk("arst_len", d, 0);
      apb_read(A_STAT, d); chk("arst_stat", d, 0);
      apb_read(A_TO, d);   chk("arst_to", d, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
APB-programmable sequencer for the vector MAC accelerator (8-bit A/B operand banks, 16-bit result bank). Software writes the element count, timeout and start. The block then issues one command per CHUNK-element slice over a valid/ready handshake and waits for a per-chunk response pulse. It reports status and a level interrupt. It sits on the peripheral APB bus beside the operand/result slave and drives the compute core's command port.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4 KB slave window)
NUM_ELEM, 1024, maximum element pairs per job
CHUNK, 16, elements processed per command
CHUNK_IDX_W, 6, width of chunk index, equal to clog2(NUM_ELEM/CHUNK)
TO_W, 16, timeout counter width

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
PADDR  in  APB_ADDR_WIDTH  APB address; word index is PADDR[11:2]
PWDATA  in  32  APB write data
PWRITE  in  1  APB write strobe
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data (combinational)
PREADY  out  1  tied 1
PSLVERR  out  1  error response, combinational
cmd_valid  out  1  chunk command valid
cmd_ready  in  1  core accepts command
cmd_chunk  out  CHUNK_IDX_W  chunk index being issued
cmd_last  out  1  final chunk of the job
rsp_valid  in  1  one-cycle pulse: issued chunk finished
irq_o  out  1  level interrupt

Behaviour:
- Write access is PSEL&PENABLE&PWRITE. Register map by byte offset:
  - 0x00 CTRL: bit0 start (W1, self-clearing), bit1 irq_en (R/W), bit2 abort (W1).
  - 0x04 LEN: [10:0] element count; writes above NUM_ELEM saturate to NUM_ELEM.
  - 0x08 STATUS: bit0 busy (RO), bit1 done (sticky, W1C), bit2 timeout (sticky, W1C), bit3 spurious (sticky, W1C), [21:16] chunks completed (RO).
  - 0x0C TIMEOUT: [TO_W-1:0]; 0 disables the timeout.
  - Other offsets read 32'hFFFF_FFFF; writes to them are ignored.
- Reset values: all registers 0, FSM IDLE, cmd_valid 0, cmd_chunk 0, cmd_last 0, irq_o 0, PSLVERR 0.
- Writes to LEN or TIMEOUT while busy: ignored and PSLVERR=1 in that access cycle. All other accesses return PSLVERR=0.
- nchunk = ceil(LEN/CHUNK); last index = nchunk-1.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: start write at edge t → ISSUE at t+1 with cmd_chunk=0, completed count cleared. If LEN=0, stay IDLE and set done at t+1; no command is issued.
  - ISSUE: cmd_valid=1. cmd_chunk and cmd_last are held stable until cmd_ready. Handshake at edge → WAIT, timeout counter cleared.
  - WAIT: cmd_valid=0. Counter increments each cycle.
    - rsp_valid on the last chunk → IDLE; done set and completed count incremented on the same edge.
    - rsp_valid on any other chunk → ISSUE with chunk+1.
    - Counter reaching TIMEOUT (when TIMEOUT≠0) → IDLE and timeout set.
- busy = (state ≠ IDLE).
- Start while busy: ignored.
- Abort: any state → IDLE at the next edge and cmd_valid drops immediately (permitted valid withdrawal). No sticky bit is set.
- rsp_valid outside WAIT: ignored for sequencing and sets spurious.
- Simultaneous events:
  - Abort and start in the same write: abort wins and no job starts.
  - rsp_valid and timeout expiry in the same cycle: the response wins.
  - Hardware set and W1C of the same sticky bit in the same cycle: the set wins.
- Reset asserted mid-job: immediate return to reset values; the core must be reset with it.
- irq_o = irq_en & (done | timeout), registered (one cycle after the sticky bit sets).

Decomposition:
- acc_seq_pkg holds: the FSM state enum, register offset constants, STATUS/CTRL bit-position constants, and the default CHUNK/NUM_ELEM values.
- One sub-module, acc_seq_regif, contains the APB decode, the register file, sticky set/W1C priority, and PRDATA/PSLVERR generation.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LEN=40, TIMEOUT=0, start, core always ready, rsp_valid 3 cycles after each accept → chunks 0,1,2 issued, cmd_last only on 2; STATUS=0x0003_0002 after completion; irq_o=1 if irq_en.
- cmd_ready held low 10 cycles during ISSUE → cmd_valid stays 1, cmd_chunk stable, and the timeout counter does not run.
- TIMEOUT=5, no rsp_valid → IDLE 5 cycles after accept, STATUS bit2=1. A W1C of 0x4 clears it, and irq_o drops one cycle later.
- Abort written while in WAIT on chunk 1 of LEN=64 → busy=0 next cycle, no done; a new start reissues from chunk 0.
- Write LEN=2000 → reads back 1024. Write LEN while busy → PSLVERR=1 and value unchanged. LEN=0 start → done set, no cmd_valid.
- rsp_valid pulse in IDLE → spurious=1. Asserting HRESETn low mid-ISSUE → cmd_valid=0 asynchronously and all registers 0.
